// File: rtl/led_sweep_sequencer.sv
// rtl/led_sweep_sequencer.sv - forward/backward sweep sequencer with dwell, loop count and registered LED mux
// Optional FWD/BWD watchdog with sticky error state: define LED_SEQ_TIMEOUT_EN.
module led_sweep_sequencer #(
  parameter int DWELL   = 4,
  parameter int LOOPS   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       fwd_done,
  input  logic       bwd_done,
  input  logic [3:0] fwd_leds,
  input  logic [3:0] bwd_leds,
  output logic       fwd_en,
  output logic       bwd_en,
  output logic [3:0] leds_out,
  output logic       busy,
  output logic       finished,
  output logic       timeout_err
);

  typedef enum logic [2:0] {IDLE, FWD, FWD_HOLD, BWD, BWD_HOLD, ERR} state_t;

  localparam int            DW         = $clog2(DWELL + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [7:0]    LOOPS_CFG  = 8'(LOOPS);

  state_t        state, next_state;
  logic [DW-1:0] dwell_cnt;
  logic [7:0]    loop_cnt;
  logic [7:0]    loop_inc;
  logic          fresh;
  logic          timed_out;
  logic          fwd_en_d, bwd_en_d, finished_d, err_d;
  logic [3:0]    leds_d;

  assign loop_inc = loop_cnt + 8'd1;

`ifdef LED_SEQ_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] to_cnt;

  // Counts cycles spent in FWD/BWD; any state change (including entry) clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      to_cnt <= '0;
    else if ((state == FWD || state == BWD) && next_state == state)
      to_cnt <= to_cnt + TW'(1);
    else
      to_cnt <= '0;
  end

  assign timed_out = (to_cnt == TO_LAST);
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      fresh     <= 1'b0;
      dwell_cnt <= '0;
      loop_cnt  <= '0;
    end else begin
      state     <= next_state;
      // Marks the first cycle of a state so a done left over from the previous phase is ignored.
      fresh     <= (next_state != state);
      if ((state == FWD_HOLD || state == BWD_HOLD) && next_state == state)
        dwell_cnt <= dwell_cnt + DW'(1);
      else
        dwell_cnt <= '0;
      if (stop || state == IDLE)
        loop_cnt <= '0;
      else if (state == BWD_HOLD && next_state != BWD_HOLD)
        loop_cnt <= loop_inc;
    end
  end

  always_comb begin
    next_state = state;
    if (stop) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:     if (start) next_state = FWD;
        FWD:      if (fwd_done && !fresh) next_state = FWD_HOLD;
                  else if (timed_out)     next_state = ERR;
        FWD_HOLD: if (dwell_cnt == DWELL_LAST) next_state = BWD;
        BWD:      if (bwd_done && !fresh) next_state = BWD_HOLD;
                  else if (timed_out)     next_state = ERR;
        BWD_HOLD: if (dwell_cnt == DWELL_LAST)
                    next_state = (LOOPS != 0 && loop_inc == LOOPS_CFG) ? IDLE : FWD;
        ERR:      next_state = ERR;
        default:  next_state = IDLE;
      endcase
    end
  end

  // Registered outputs decode the upcoming state so the enable handover happens on one edge.
  always_comb begin
    fwd_en_d   = (next_state == FWD) || (next_state == FWD_HOLD);
    bwd_en_d   = (next_state == BWD) || (next_state == BWD_HOLD);
    leds_d     = fwd_en_d ? fwd_leds : (bwd_en_d ? bwd_leds : 4'b0000);
    finished_d = !stop && (state == BWD_HOLD) && (next_state == IDLE);
    err_d      = (next_state == ERR);
    busy       = (state != IDLE) && (state != ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_en      <= 1'b0;
      bwd_en      <= 1'b0;
      leds_out    <= 4'b0000;
      finished    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      fwd_en      <= fwd_en_d;
      bwd_en      <= bwd_en_d;
      leds_out    <= leds_d;
      finished    <= finished_d;
      timeout_err <= err_d;
    end
  end

endmodule

// File: doc/led_sweep_sequencer.md
# led_sweep_sequencer

Upstream controller for the LED sweep stages. Drives the `en` inputs of a forward sweeper and a backward sweeper, waits for each `done`, and holds the final pattern for a dwell time. It then hands over to the other direction and repeats for a configured number of loops. It also muxes the two sweepers' LED buses onto one registered board output.

## Interface
- `DWELL`, 4: cycles the end-of-sweep pattern is held before the direction change; ≥1.
- `LOOPS`, 2: forward+backward pairs per run; 0 means run until `stop`; ≤255.
- `TIMEOUT`, 64: maximum cycles allowed in an active sweep state before an error; used only with the macro.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: begin a run; sampled only in IDLE.
- `stop` in 1: synchronous abort from any state.
- `fwd_done` in 1: done from the forward sweeper.
- `bwd_done` in 1: done from the backward sweeper.
- `fwd_leds` in 4: LED bus from the forward sweeper.
- `bwd_leds` in 4: LED bus from the backward sweeper.
- `fwd_en` out 1: enable to the forward sweeper; registered.
- `bwd_en` out 1: enable to the backward sweeper; registered.
- `leds_out` out 4: muxed LED output; registered.
- `busy` out 1: high in every state except IDLE and ERR.
- `finished` out 1: one-cycle pulse when a finite run completes.
- `timeout_err` out 1: sticky error flag.

## Operation
- States: IDLE, FWD, FWD_HOLD, BWD, BWD_HOLD, ERR.
- Reset values:
  - all outputs 0
  - state IDLE
  - dwell counter, loop counter and timeout counter 0.
- IDLE:
  - `start`=1 and `stop`=0 → FWD.
  - Loop counter cleared.
- FWD:
  - `fwd_en`=1, `bwd_en`=0.
  - `fwd_done` is ignored in the first cycle of the state, so a stale done cannot be taken.
  - From the second cycle on, `fwd_done`=1 → FWD_HOLD.
- FWD_HOLD:
  - `fwd_en` stays 1 so the sweeper keeps its final pattern.
  - The dwell counter starts at 0 on entry; at `DWELL`-1 → BWD.
  - The state therefore lasts exactly `DWELL` cycles.
- BWD / BWD_HOLD:
  - Mirror of FWD / FWD_HOLD using `bwd_en` and `bwd_done`.
  - On leaving BWD_HOLD the loop counter increments.
  - If `LOOPS`≠0 and the incremented count equals `LOOPS` → IDLE with `finished`=1 for one cycle.
  - Otherwise → FWD.
- Enable handover: `fwd_en` falls and `bwd_en` rises on the same edge, and the reverse. The two enables are never high together.
- `leds_out`:
  - FWD and FWD_HOLD: `fwd_leds`.
  - BWD and BWD_HOLD: `bwd_leds`.
  - IDLE and ERR: 4'b0000.
- `stop`=1 in any state:
  - → IDLE next edge.
  - Enables, `leds_out` and counters cleared.
  - `finished` is not pulsed.
  - `timeout_err` is cleared.
- Simultaneous `start` and `stop` in IDLE: `stop` wins; the block stays in IDLE.
- `start` outside IDLE is ignored.
- With `LOOPS`=0 the loop counter wraps 255→0 silently and the run never ends on its own.

## Timing
- `start` is sampled at edge k.
  - State FWD and `fwd_en`=1 are visible after edge k.
  - `leds_out` follows `fwd_leds` with 1-cycle register latency.
- `done` sampled high at edge m → HOLD entered at m.
  - Direction change at edge m+`DWELL`.
- The sweepers' `done` inputs are treated as synchronous to `clk`; no synchronizers are used.
- `rst` mid-operation forces every output to 0 immediately, without waiting for a clock edge.

## Configuration
- `LED_SEQ_TIMEOUT_EN` defined:
  - A counter runs in FWD and BWD only, cleared on each entry.
  - Reaching `TIMEOUT` cycles without the respective `done` → ERR.
  - In ERR: `fwd_en`=`bwd_en`=0, `leds_out`=0, `timeout_err`=1.
  - ERR is left only via `stop` or `rst`.
- `LED_SEQ_TIMEOUT_EN` undefined:
  - No timeout counter and ERR is unreachable.
  - `timeout_err` tied to 0.
  - A missing `done` stalls the FWD/BWD state indefinitely.

## Test plan
- Basic run, `DWELL`=2, `LOOPS`=1, real sweepers attached:
  - Pulse `start`.
  - Expect `leds_out` 0001→…→1000, held 2 cycles, then 1000→…→0001, held 2 cycles.
  - Then `finished` pulses once, `busy`=0, `leds_out`=0.
- Run with `LOOPS`=0: let 3 full pairs complete, then assert `stop` mid-BWD.
  - Next edge: IDLE, `bwd_en`=0, `leds_out`=0.
  - `finished` never pulsed.
- `start`=`stop`=1 in the same IDLE cycle: expect the state to stay IDLE and `fwd_en` to stay 0.
- Assert `rst` asynchronously in BWD_HOLD: all outputs 0 before the next clock edge.
  - A subsequent `start` begins with FWD.
- With the macro, `TIMEOUT`=8, `fwd_done` held 0:
  - ERR and `timeout_err`=1 after 8 FWD cycles.
  - `start` is ignored in ERR.
  - `stop` clears the error and returns to IDLE.
- Pulse `start` during FWD_HOLD: no effect on state or counters; sequence timing unchanged.
